rs_entry_alloc: RTL and testbench



---
 rtl/rs_entry_alloc.sv | 105 ++++++++++
 tb/tb_rs_entry_alloc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_entry_alloc.sv
// rs_entry_alloc: reservation-station entry allocator; feeds free entries to the priority selector and consumes its grants.
// Latency: alloc_ok/alloc_idx are combinational from the grant lines; busy/free_cnt update one edge later.
// Backpressure: dispatch_stall (registered state plus reset only) holds the whole dispatch bundle when fewer than REQS entries are free.
// Optional feature macro: RS_ALLOC_RELEASE_BYPASS_EN -- entries released this cycle may be reallocated this cycle.
// The release input is named release_vec because "release" is a reserved word in SystemVerilog.
module rs_entry_alloc #(
  parameter  int WIDTH = 16,
  parameter  int REQS  = 3,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [REQS-1:0]         dispatch_valid,
  input  logic [WIDTH-1:0]        release_vec,
  input  logic [WIDTH*REQS-1:0]   psel_gnt_bus,
  output logic [WIDTH-1:0]        psel_req,
  output logic                    psel_en,
  output logic [REQS-1:0]         alloc_ok,
  output logic [REQS*IDX_W-1:0]   alloc_idx,
  output logic                    dispatch_stall,
  output logic [WIDTH-1:0]        busy,
  output logic [CNT_W-1:0]        free_cnt
);

  logic [WIDTH-1:0] alloc_mask;
  logic [WIDTH-1:0] busy_nxt;
  logic [WIDTH-1:0] gnt_line;
  logic [IDX_W-1:0] enc;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) c = c + CNT_W'(v[k]);
    return c;
  endfunction

  // Request vector and stall: both derive only from registered occupancy (and release under bypass), never from dispatch_valid.
`ifdef RS_ALLOC_RELEASE_BYPASS_EN
  logic [CNT_W:0] avail_cnt;
  always_comb begin
    psel_req       = ~busy | release_vec;
    avail_cnt      = {1'b0, free_cnt} + {1'b0, popcnt(release_vec)};
    dispatch_stall = reset | (avail_cnt < (CNT_W+1)'(REQS));
  end
`else
  always_comb begin
    psel_req       = ~busy;
    dispatch_stall = reset | (free_cnt < CNT_W'(REQS));
  end
`endif

  assign psel_en = ~reset;

  // Accept each slot with a live grant, binary-encode its grant line and collect the allocation mask.
  always_comb begin
    alloc_ok   = '0;
    alloc_idx  = '0;
    alloc_mask = '0;
    gnt_line   = '0;
    enc        = '0;
    for (int i = 0; i < REQS; i++) begin
      gnt_line = psel_gnt_bus[i*WIDTH +: WIDTH];
      enc      = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (gnt_line[j]) enc = enc | IDX_W'(j);
      end
      if (dispatch_valid[i] && !dispatch_stall && !squash && (|gnt_line)) begin
        alloc_ok[i]                  = 1'b1;
        alloc_idx[i*IDX_W +: IDX_W]  = enc;
        alloc_mask                   = alloc_mask | gnt_line;
      end
    end
  end

  // Allocation is applied after release so a bypassed same-entry release/alloc leaves the entry busy.
  always_comb begin
    busy_nxt = (busy & ~release_vec) | alloc_mask;
  end

  // Occupancy register: reset and squash both clear everything; free_cnt tracks the new busy map.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      busy     <= '0;
      free_cnt <= CNT_W'(WIDTH);
    end else begin
      busy     <= busy_nxt;
      free_cnt <= CNT_W'(WIDTH) - popcnt(busy_nxt);
    end
  end

`ifndef SYNTHESIS
  // Grant lines must be one-hot or zero outside reset (the selector floods all ones during reset).
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REQS; i++) begin
        assert ($onehot0(psel_gnt_bus[i*WIDTH +: WIDTH]))
          else $error("rs_entry_alloc: grant line %0d has more than one bit set", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_entry_alloc.sv
// tb_rs_entry_alloc: directed test-plan sequence followed by randomized traffic, checked against a queue-based model.
// Latency: comb outputs sampled at the falling edge; registered outputs checked after the rising edge.
// Backpressure: stall and all-or-nothing acceptance are predicted by the model from its own occupancy.
module tb_rs_entry_alloc;
  localparam int WIDTH = 16;
  localparam int REQS  = 3;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  logic                  clock;
  logic                  reset;
  logic                  squash;
  logic [REQS-1:0]       dispatch_valid;
  logic [WIDTH-1:0]      release_vec;
  logic [WIDTH*REQS-1:0] gnt_bus;
  logic [WIDTH-1:0]      psel_req;
  logic                  psel_en;
  logic [REQS-1:0]       alloc_ok;
  logic [REQS*IDX_W-1:0] alloc_idx;
  logic                  dispatch_stall;
  logic [WIDTH-1:0]      busy;
  logic [CNT_W-1:0]      free_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0]      m_busy;
  logic [REQS-1:0]       last_ok;
  logic [REQS*IDX_W-1:0] last_idx;
  logic                  last_stall;
  logic                  last_en;
  logic [WIDTH-1:0]      saved_busy;

  rs_entry_alloc #(.WIDTH(WIDTH), .REQS(REQS)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .dispatch_valid (dispatch_valid),
    .release_vec    (release_vec),
    .psel_gnt_bus   (gnt_bus),
    .psel_req       (psel_req),
    .psel_en        (psel_en),
    .alloc_ok       (alloc_ok),
    .alloc_idx      (alloc_idx),
    .dispatch_stall (dispatch_stall),
    .busy           (busy),
    .free_cnt       (free_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Selector stand-in: even lines take the lowest remaining request, odd lines the highest; all ones in reset.
  logic [WIDTH-1:0] sel_rem;
  int               sel_pick;
  always_comb begin
    gnt_bus  = '0;
    sel_rem  = psel_req;
    sel_pick = -1;
    if (reset) begin
      gnt_bus = '1;
    end else begin
      for (int i = 0; i < REQS; i++) begin
        sel_pick = -1;
        if (i % 2 == 0) begin
          for (int j = WIDTH - 1; j >= 0; j--) if (sel_rem[j]) sel_pick = j;
        end else begin
          for (int j = 0; j < WIDTH; j++) if (sel_rem[j]) sel_pick = j;
        end
        if (sel_pick >= 0) begin
          gnt_bus[i*WIDTH + sel_pick] = 1'b1;
          sel_rem[sel_pick]           = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: predict from the model, compare comb outputs at negedge and state, then advance the model.
  task automatic step(input logic [REQS-1:0] v, input logic [WIDTH-1:0] rel,
                      input logic sq, input logic rst);
    logic [WIDTH-1:0]      req;
    logic [WIDTH-1:0]      amask;
    logic [REQS-1:0]       eok;
    logic [REQS*IDX_W-1:0] eidx;
    logic                  stall;
    int                    free_q[$];
    int                    nfree;
    int                    nrel;
    int                    g;
    dispatch_valid = v;
    release_vec    = rel;
    squash         = sq;
    reset          = rst;
    @(negedge clock);
    nfree = 0;
    for (int k = 0; k < WIDTH; k++) if (!m_busy[k]) nfree++;
    nrel  = $countones(rel);
`ifdef RS_ALLOC_RELEASE_BYPASS_EN
    req   = ~m_busy | rel;
    stall = rst || ((nfree + nrel) < REQS);
`else
    req   = ~m_busy;
    stall = rst || (nfree < REQS);
`endif
    free_q = {};
    for (int k = 0; k < WIDTH; k++) if (req[k]) free_q.push_back(k);
    eok = '0; eidx = '0; amask = '0;
    for (int i = 0; i < REQS; i++) begin
      if (!rst && free_q.size() > 0) begin
        g = (i % 2 == 0) ? free_q.pop_front() : free_q.pop_back();
        if (v[i] && !stall && !sq) begin
          eok[i]                  = 1'b1;
          eidx[i*IDX_W +: IDX_W]  = g[IDX_W-1:0];
          amask[g]                = 1'b1;
        end
      end
    end
    last_ok    = alloc_ok;
    last_idx   = alloc_idx;
    last_stall = dispatch_stall;
    last_en    = psel_en;
    chk("psel_en",   64'(psel_en),        64'(!rst));
    chk("psel_req",  64'(psel_req),       64'(req));
    chk("stall",     64'(dispatch_stall), 64'(stall));
    chk("alloc_ok",  64'(alloc_ok),       64'(eok));
    chk("alloc_idx", 64'(alloc_idx),      64'(eidx));
    chk("busy",      64'(busy),           64'(m_busy));
    chk("free_cnt",  64'(free_cnt),       64'(nfree));
    @(posedge clock);
    if (rst || sq) m_busy = '0;
    else           m_busy = (m_busy & ~rel) | amask;
    #1;
  endtask

  initial begin
    logic [2:0]       n;
    logic [WIDTH-1:0] r;
    reset = 1'b1; squash = 1'b0; dispatch_valid = '0; release_vec = '0;
    @(posedge clock); @(posedge clock); #1;
    m_busy = '0;

    // Reset state
    step(3'b000, 16'h0000, 1'b0, 1'b1);
    chk("rst_en", 64'(last_en), 64'd0);

    // First dispatch into an empty station
    step(3'b111, 16'h0000, 1'b0, 1'b0);
    chk("first_ok",   64'(last_ok),  64'(3'b111));
    chk("first_idx",  64'(last_idx), 64'({4'd1, 4'd15, 4'd0}));
    chk("first_busy", 64'(busy),     64'(16'h8003));
    chk("first_free", 64'(free_cnt), 64'd13);

    // Squash with dispatch and release in flight
    step(3'b111, 16'h0001, 1'b1, 1'b0);
    chk("sq_ok",   64'(last_ok),  64'd0);
    chk("sq_busy", 64'(busy),     64'd0);
    chk("sq_free", 64'(free_cnt), 64'd16);

    // Fill down to two free entries, then a full bundle must stall
    step(3'b111, 16'h0000, 1'b0, 1'b0);
    step(3'b011, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(3'b111, 16'h0000, 1'b0, 1'b0);
    chk("two_free", 64'(free_cnt), 64'd2);
    saved_busy = busy;
    step(3'b111, 16'h0000, 1'b0, 1'b0);
    chk("low_stall", 64'(last_stall), 64'd1);
    chk("low_ok",    64'(last_ok),    64'd0);
    chk("low_busy",  64'(busy),       64'(saved_busy));

    // Reset mid-operation while the selector floods all ones
    step(3'b111, 16'h0000, 1'b0, 1'b1);
    chk("mrst_ok",   64'(last_ok), 64'd0);
    chk("mrst_en",   64'(last_en), 64'd0);
    chk("mrst_busy", 64'(busy),    64'd0);

    // Fill completely: 16 -> 13 -> 12 -> 9 -> 6 -> 3 -> 0
    step(3'b111, 16'h0000, 1'b0, 1'b0);
    step(3'b001, 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(3'b111, 16'h0000, 1'b0, 1'b0);
    chk("full_busy",  64'(busy),           64'(16'hFFFF));
    chk("full_req",   64'(psel_req),       64'd0);
    chk("full_stall", 64'(dispatch_stall), 64'd1);

    // Releases while full, then the next dispatch picks {0,8,2}
    step(3'b000, 16'h0005, 1'b0, 1'b0);
    chk("rel_free2", 64'(free_cnt), 64'd2);
    step(3'b000, 16'h0100, 1'b0, 1'b0);
`ifndef RS_ALLOC_RELEASE_BYPASS_EN
    chk("rel_stall_held", 64'(last_stall), 64'd1);
`endif
    chk("rel_free3", 64'(free_cnt),       64'd3);
    chk("rel_go",    64'(dispatch_stall), 64'd0);
    step(3'b111, 16'h0000, 1'b0, 1'b0);
    chk("reuse_idx", 64'(last_idx), 64'({4'd2, 4'd8, 4'd0}));
    chk("reuse_ok",  64'(last_ok),  64'(3'b111));

    // Single free entry plus a two-entry release alongside a two-slot dispatch
    step(3'b000, 16'h0001, 1'b0, 1'b0);
    chk("one_free_busy", 64'(busy), 64'(16'hFFFE));
    step(3'b011, 16'h0006, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      n = 3'($urandom_range(0, REQS));
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(3'((4'd1 << n) - 4'd1), r, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
